rob_multi_commit: RTL

//  Parametrised reorder buffer: NUM_WB writeback ports, up to COMMIT_WIDTH in-order commits/cycle.
//  Per-entry precise exception record (ITLB at alloc, MEM at writeback); full flush on exception.

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_commit_select.sv | 54 +++++
 rtl/rob_multi_commit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared exception causes, entry record and index wrap helper for the reorder buffer
package rob_pkg;

    typedef enum logic [1:0] {EX_NONE, EX_ITLB, EX_MEM} ex_cause_t;

    typedef struct packed {
        logic      valid;
        logic      ready;
        logic      exc;
        logic      is_store;
        ex_cause_t cause;
    } rob_entry_t;

    localparam rob_entry_t ROB_INVALID_ENTRY = '{valid: 1'b0, ready: 1'b0, exc: 1'b0, is_store: 1'b0, cause: EX_NONE};

    function automatic int inc_wrap(int idx, int amt, int n);
        return (idx + amt >= n) ? idx + amt - n : idx + amt;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: scans the commit window from head for retiring slots, the store slot and a faulting slot
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int N            = 16,
    parameter int COMMIT_WIDTH = 2,
    parameter int IDW          = $clog2(N),
    parameter int CW           = $clog2(N + 1)
) (
    input  rob_entry_t                   ent [N],
    input  logic [IDW-1:0]               head,
    input  logic [CW-1:0]                count,
    output logic [COMMIT_WIDTH-1:0]      mask,
    output logic [COMMIT_WIDTH*IDW-1:0]  slot_id,
    output logic                         st_found,
    output logic [IDW-1:0]               st_idx,
    output logic                         exc_found,
    output logic [IDW-1:0]               exc_idx
);

    logic           go;
    logic [IDW-1:0] idx;

    always_comb begin
        mask      = '0;
        slot_id   = '0;
        st_found  = 1'b0;
        st_idx    = '0;
        exc_found = 1'b0;
        exc_idx   = '0;
        go        = 1'b1;
        idx       = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx = IDW'(inc_wrap(int'(head), k, N));
            slot_id[k*IDW +: IDW] = idx;
            if (go && k < int'(count) && ent[idx].valid) begin
                if (ent[idx].ready && !ent[idx].exc && !st_found) begin
                    mask[k] = 1'b1;
                    if (ent[idx].is_store) begin
                        st_found = 1'b1;
                        st_idx   = idx;
                    end
                end else begin
                    go        = 1'b0;
                    exc_found = ent[idx].ready && ent[idx].exc;
                    exc_idx   = idx;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with multi-port writeback, in-order multi-commit and precise flush on exception
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int N              = 16,
    parameter int WORD_SIZE      = 32,
    parameter int REG_INDEX_SIZE = 5,
    parameter int NUM_WB         = 3,
    parameter int COMMIT_WIDTH   = 2,
    localparam int IDW           = $clog2(N)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                alloc_req,
    input  logic                                alloc_is_store,
    input  logic [REG_INDEX_SIZE-1:0]           alloc_rd,
    input  logic [WORD_SIZE-1:0]                alloc_pc,
    input  logic                                alloc_exc,
    output logic                                alloc_grant,
    output logic [IDW-1:0]                      alloc_id,
    output logic                                full,
    output logic                                empty,
    input  logic [NUM_WB-1:0]                   wb_valid,
    input  logic [NUM_WB*IDW-1:0]               wb_id,
    input  logic [NUM_WB*WORD_SIZE-1:0]         wb_value,
    input  logic [NUM_WB-1:0]                   wb_exc,
    input  logic [NUM_WB*WORD_SIZE-1:0]         wb_addr,
    input  logic [IDW-1:0]                      rs1_id,
    input  logic [IDW-1:0]                      rs2_id,
    output logic [WORD_SIZE-1:0]                bypass_s1,
    output logic [WORD_SIZE-1:0]                bypass_s2,
    output logic                                bypass_s1_valid,
    output logic                                bypass_s2_valid,
    output logic [COMMIT_WIDTH-1:0]             commit_valid,
    output logic [COMMIT_WIDTH*REG_INDEX_SIZE-1:0] commit_rd,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0]   commit_value,
    output logic [COMMIT_WIDTH*IDW-1:0]         commit_id,
    output logic                                sb_store_permission,
    output logic [IDW-1:0]                      sb_rob_id,
    output logic                                exception,
    output logic [WORD_SIZE-1:0]                ex_pc,
    output logic [WORD_SIZE-1:0]                ex_addr,
    output logic [1:0]                          ex_cause
);

    localparam int CW = $clog2(N + 1);

    rob_entry_t                ent    [N];
    logic [REG_INDEX_SIZE-1:0] rd_q   [N];
    logic [WORD_SIZE-1:0]      pc_q   [N];
    logic [WORD_SIZE-1:0]      val_q  [N];
    logic [WORD_SIZE-1:0]      addr_q [N];
    logic [IDW-1:0]            head, tail;
    logic [CW-1:0]             count, n_commit;
    logic [COMMIT_WIDTH-1:0]   mask;
    logic [COMMIT_WIDTH*IDW-1:0] slot_id;
    logic                      st_found, exc_found;
    logic [IDW-1:0]            st_idx, exc_idx;

    rob_commit_select #(.N(N), .COMMIT_WIDTH(COMMIT_WIDTH), .IDW(IDW), .CW(CW)) u_sel (
        .ent       (ent),
        .head      (head),
        .count     (count),
        .mask      (mask),
        .slot_id   (slot_id),
        .st_found  (st_found),
        .st_idx    (st_idx),
        .exc_found (exc_found),
        .exc_idx   (exc_idx)
    );

    assign full                = count == CW'(N);
    assign empty               = count == '0;
    assign alloc_grant         = alloc_req && !full && !exception;
    assign alloc_id            = tail;
    assign bypass_s1           = val_q[rs1_id];
    assign bypass_s2           = val_q[rs2_id];
    assign bypass_s1_valid     = ent[rs1_id].valid && ent[rs1_id].ready && !ent[rs1_id].exc;
    assign bypass_s2_valid     = ent[rs2_id].valid && ent[rs2_id].ready && !ent[rs2_id].exc;
    assign commit_valid        = mask;
    assign sb_store_permission = st_found;
    assign sb_rob_id           = st_found ? st_idx : '0;
    assign exception           = exc_found;
    assign ex_pc               = exc_found ? pc_q[exc_idx] : '0;
    assign ex_addr             = exc_found ? addr_q[exc_idx] : '0;
    assign ex_cause            = exc_found ? ent[exc_idx].cause : EX_NONE;

    always_comb begin
        commit_rd    = '0;
        commit_value = '0;
        commit_id    = '0;
        n_commit     = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (mask[k]) begin
                commit_rd[k*REG_INDEX_SIZE +: REG_INDEX_SIZE] = rd_q[slot_id[k*IDW +: IDW]];
                commit_value[k*WORD_SIZE +: WORD_SIZE]        = val_q[slot_id[k*IDW +: IDW]];
                commit_id[k*IDW +: IDW]                       = slot_id[k*IDW +: IDW];
                n_commit                                      = n_commit + CW'(1);
            end
        end
    end

    // an exception flushes the whole buffer, so pending writebacks and the alloc that edge are lost
    always_ff @(posedge clk) begin
        if (!rst || exception) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < N; i++) ent[i] <= ROB_INVALID_ENTRY;
        end else begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && ent[wb_id[p*IDW +: IDW]].valid) begin
                    ent[wb_id[p*IDW +: IDW]].ready <= 1'b1;
                    ent[wb_id[p*IDW +: IDW]].exc   <= wb_exc[p];
                    ent[wb_id[p*IDW +: IDW]].cause <= EX_MEM;
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (mask[k]) begin
                    ent[slot_id[k*IDW +: IDW]].valid <= 1'b0;
                    ent[slot_id[k*IDW +: IDW]].ready <= 1'b0;
                end
            end
            if (alloc_grant) begin
                ent[tail] <= '{valid: 1'b1, ready: alloc_exc, exc: alloc_exc, is_store: alloc_is_store, cause: EX_ITLB};
                tail      <= IDW'(inc_wrap(int'(tail), 1, N));
            end
            head  <= IDW'(inc_wrap(int'(head), int'(n_commit), N));
            count <= count + CW'(alloc_grant) - n_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                rd_q[i]   <= '0;
                pc_q[i]   <= '0;
                val_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (!exception) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && ent[wb_id[p*IDW +: IDW]].valid) begin
                    val_q[wb_id[p*IDW +: IDW]]  <= wb_value[p*WORD_SIZE +: WORD_SIZE];
                    addr_q[wb_id[p*IDW +: IDW]] <= wb_addr[p*WORD_SIZE +: WORD_SIZE];
                end
            end
            if (alloc_grant) begin
                rd_q[tail]   <= alloc_rd;
                pc_q[tail]   <= alloc_pc;
                val_q[tail]  <= '0;
                addr_q[tail] <= '0;
            end
        end
    end

    // two ports targeting the same entry in one cycle is an upstream bug
    always @(posedge clk) begin
        for (int p = 0; p < NUM_WB; p++)
            for (int q = p + 1; q < NUM_WB; q++)
                assert (!(rst && wb_valid[p] && wb_valid[q] && wb_id[p*IDW +: IDW] == wb_id[q*IDW +: IDW]));
    end

endmodule
